// File: rtl/gelato_warp_pc_updater_pkg.sv
// Shared types, widths and opcode constants for the warp PC updater.
// Build-time sizing comes from the SPLIT_TABLE_NUM / THREAD_NUM / WARP_NUM_WIDTH macros.
`ifndef SPLIT_TABLE_NUM
`define SPLIT_TABLE_NUM 4
`endif
`ifndef THREAD_NUM
`define THREAD_NUM 8
`endif
`ifndef WARP_NUM_WIDTH
`define WARP_NUM_WIDTH 4
`endif

package gelato_warp_pc_updater_pkg;

  localparam int unsigned SPLIT_TABLE_NUM = `SPLIT_TABLE_NUM;
  localparam int unsigned SPLIT_W         = (SPLIT_TABLE_NUM > 1) ? $clog2(SPLIT_TABLE_NUM) : 1;
  localparam int unsigned THREAD_NUM      = `THREAD_NUM;
  localparam int unsigned WARP_W          = `WARP_NUM_WIDTH;
  localparam int unsigned PC_W            = 32;
  localparam int unsigned INST_W          = 32;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef logic [PC_W-1:0]       pc_t;
  typedef logic [INST_W-1:0]     inst_t;
  typedef logic [SPLIT_W-1:0]    split_num_t;
  typedef logic [THREAD_NUM-1:0] thread_mask_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } fetch_state_t;

  // Write-back payload toward the split table.
  typedef struct packed {
    split_num_t num;
    pc_t        pc;
    logic       stall;
  } upd_req_t;

  function automatic logic is_ctrl_flow(input inst_t inst, input logic [6:0] br_op,
                                        input logic [6:0] jal_op);
    return (inst[6:0] == br_op) || (inst[6:0] == jal_op);
  endfunction

endpackage

// File: rtl/gelato_warp_pc_updater_update_arbiter.sv
// Orders split-table updates: resolves win, a displaced fetch write-back waits
// one slot in a single-entry holding register. Outputs are registered pulses.
module gelato_warp_pc_updater_update_arbiter
  import gelato_warp_pc_updater_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic       fetch_valid_i,
  input  upd_req_t   fetch_req_i,
  input  logic       resolve_valid_i,
  input  split_num_t resolve_num_i,
  input  pc_t        resolve_pc_i,
  output logic       upd_valid_o,
  output upd_req_t   upd_o
);

  logic     upd_valid_q, upd_valid_d;
  upd_req_t upd_q, upd_d;
  logic     hold_valid_q, hold_valid_d;
  upd_req_t hold_q, hold_d;

  always_comb begin
    upd_valid_d  = 1'b0;
    upd_d        = upd_q;
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    if (resolve_valid_i) begin
      upd_valid_d = 1'b1;
      upd_d       = '{num: resolve_num_i, pc: resolve_pc_i, stall: 1'b0};
      if (fetch_valid_i) begin
        hold_valid_d = 1'b1;
        hold_d       = fetch_req_i;
      end
    end else if (hold_valid_q) begin
      upd_valid_d  = 1'b1;
      upd_d        = hold_q;
      hold_valid_d = fetch_valid_i;
      if (fetch_valid_i) begin
        hold_d = fetch_req_i;
      end
    end else if (fetch_valid_i) begin
      upd_valid_d = 1'b1;
      upd_d       = fetch_req_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid_q  <= 1'b0;
      upd_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else if (rdy) begin
      upd_valid_q  <= upd_valid_d;
      upd_q        <= upd_d;
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
    end
  end

  assign upd_valid_o = upd_valid_q;
  assign upd_o       = upd_q;

endmodule

// File: rtl/gelato_warp_pc_updater.sv
// Per-warp fetch front end: split-table PC -> I-cache -> decode, with PC write-back.
// Optional performance counters are built when GELATO_FETCH_PERF_EN is defined.
module gelato_warp_pc_updater
  import gelato_warp_pc_updater_pkg::*;
#(
  parameter int unsigned CURRENT_WARP_NUM = 0,
  parameter logic [6:0]  BRANCH_OPCODE    = OPC_BRANCH,
  parameter logic [6:0]  JAL_OPCODE       = OPC_JAL
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  sel_valid,
  input  logic [PC_W-1:0]       sel_pc,
  input  logic [SPLIT_W-1:0]    sel_num,
  output logic                  upd_valid,
  output logic [SPLIT_W-1:0]    upd_num,
  output logic [PC_W-1:0]       upd_pc,
  output logic                  upd_stall,
  input  logic [THREAD_NUM-1:0] upd_thread_mask,
  output logic                  icache_req_valid,
  output logic [PC_W-1:0]       icache_req_addr,
  input  logic                  icache_req_ready,
  input  logic                  icache_resp_valid,
  input  logic [INST_W-1:0]     icache_resp_inst,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [INST_W-1:0]     dec_inst,
  output logic [PC_W-1:0]       dec_pc,
  output logic [THREAD_NUM-1:0] dec_thread_mask,
  output logic [SPLIT_W-1:0]    dec_split_num,
  output logic [WARP_W-1:0]     dec_warp_num,
  input  logic                  resolve_valid,
  input  logic [SPLIT_W-1:0]    resolve_num,
  input  logic [PC_W-1:0]       resolve_pc
`ifdef GELATO_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  fetch_state_t state_q, state_d;
  logic         req_valid_q, req_valid_d;
  pc_t          pc_q, pc_d;
  split_num_t   num_q, num_d;
  logic         dec_valid_q, dec_valid_d;
  inst_t        inst_q, inst_d;
  thread_mask_t mask_q, mask_d;
  logic         enter_out_c;
  logic         ctrl_flow_c;
  upd_req_t     fetch_wb_c;
  upd_req_t     upd_c;

  // Next-state and output logic for the fetch sequence.
  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    pc_d        = pc_q;
    num_d       = num_q;
    dec_valid_d = dec_valid_q;
    inst_d      = inst_q;
    mask_d      = mask_q;
    enter_out_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          pc_d        = sel_pc;
          num_d       = sel_num;
          req_valid_d = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (icache_req_ready) begin
          req_valid_d = 1'b0;
          if (icache_resp_valid) begin
            state_d     = OUT;
            enter_out_c = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (icache_resp_valid) begin
          state_d     = OUT;
          enter_out_c = 1'b1;
        end
      end
      OUT: begin
        if (dec_ready) begin
          dec_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_out_c) begin
      inst_d      = icache_resp_inst;
      mask_d      = upd_thread_mask;
      dec_valid_d = 1'b1;
    end
  end

  // Control flow parks the entry at its own PC until execute resolves it.
  always_comb begin
    ctrl_flow_c = is_ctrl_flow(icache_resp_inst, BRANCH_OPCODE, JAL_OPCODE);
    fetch_wb_c  = '{num:   num_q,
                    pc:    ctrl_flow_c ? pc_q : pc_q + PC_W'(4),
                    stall: ctrl_flow_c};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      pc_q        <= '0;
      num_q       <= '0;
      dec_valid_q <= 1'b0;
      inst_q      <= '0;
      mask_q      <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      pc_q        <= pc_d;
      num_q       <= num_d;
      dec_valid_q <= dec_valid_d;
      inst_q      <= inst_d;
      mask_q      <= mask_d;
    end
  end

  gelato_warp_pc_updater_update_arbiter u_update_arbiter (
    .clk             (clk),
    .rst_n           (rst_n),
    .rdy             (rdy),
    .fetch_valid_i   (enter_out_c),
    .fetch_req_i     (fetch_wb_c),
    .resolve_valid_i (resolve_valid),
    .resolve_num_i   (resolve_num),
    .resolve_pc_i    (resolve_pc),
    .upd_valid_o     (upd_valid),
    .upd_o           (upd_c)
  );

  assign upd_num          = upd_c.num;
  assign upd_pc           = upd_c.pc;
  assign upd_stall        = upd_c.stall;
  assign icache_req_valid = req_valid_q;
  assign icache_req_addr  = pc_q;
  assign dec_valid        = dec_valid_q;
  assign dec_inst         = inst_q;
  assign dec_pc           = pc_q;
  assign dec_thread_mask  = mask_q;
  assign dec_split_num    = num_q;
  assign dec_warp_num     = WARP_W'(CURRENT_WARP_NUM);

`ifdef GELATO_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall_cyc_c;

  // Saturating counters of decode handshakes and front-end stall cycles.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    stall_cyc_c = (state_q == REQ) || (state_q == WAIT) || ((state_q == OUT) && !dec_ready);
    if ((state_q == OUT) && dec_ready && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (stall_cyc_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (rdy) begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_gelato_warp_pc_updater.sv
// Directed self-checking bench for gelato_warp_pc_updater.
// Perf ports are connected only when GELATO_FETCH_PERF_EN is defined.
`timescale 1ns/1ps
module tb_gelato_warp_pc_updater;
  import gelato_warp_pc_updater_pkg::*;

  localparam int unsigned WARP_ID = 3;

  logic                  clk = 1'b0;
  logic                  rst_n, rdy;
  logic                  sel_valid;
  logic [31:0]           sel_pc;
  logic [SPLIT_W-1:0]    sel_num;
  logic                  upd_valid;
  logic [SPLIT_W-1:0]    upd_num;
  logic [31:0]           upd_pc;
  logic                  upd_stall;
  logic [THREAD_NUM-1:0] upd_thread_mask;
  logic                  icache_req_valid;
  logic [31:0]           icache_req_addr;
  logic                  icache_req_ready, icache_resp_valid;
  logic [31:0]           icache_resp_inst;
  logic                  dec_valid, dec_ready;
  logic [31:0]           dec_inst, dec_pc;
  logic [THREAD_NUM-1:0] dec_thread_mask;
  logic [SPLIT_W-1:0]    dec_split_num;
  logic [WARP_W-1:0]     dec_warp_num;
  logic                  resolve_valid;
  logic [SPLIT_W-1:0]    resolve_num;
  logic [31:0]           resolve_pc;
`ifdef GELATO_FETCH_PERF_EN
  logic [31:0]           perf_fetch_cnt, perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gelato_warp_pc_updater #(.CURRENT_WARP_NUM(WARP_ID)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rdy               (rdy),
    .sel_valid         (sel_valid),
    .sel_pc            (sel_pc),
    .sel_num           (sel_num),
    .upd_valid         (upd_valid),
    .upd_num           (upd_num),
    .upd_pc            (upd_pc),
    .upd_stall         (upd_stall),
    .upd_thread_mask   (upd_thread_mask),
    .icache_req_valid  (icache_req_valid),
    .icache_req_addr   (icache_req_addr),
    .icache_req_ready  (icache_req_ready),
    .icache_resp_valid (icache_resp_valid),
    .icache_resp_inst  (icache_resp_inst),
    .dec_valid         (dec_valid),
    .dec_ready         (dec_ready),
    .dec_inst          (dec_inst),
    .dec_pc            (dec_pc),
    .dec_thread_mask   (dec_thread_mask),
    .dec_split_num     (dec_split_num),
    .dec_warp_num      (dec_warp_num),
    .resolve_valid     (resolve_valid),
    .resolve_num       (resolve_num),
    .resolve_pc        (resolve_pc)
`ifdef GELATO_FETCH_PERF_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one select through to the edge that enters OUT; lat=0 means response with ready.
  task automatic drive_fetch(input logic [31:0] pc, input logic [SPLIT_W-1:0] num,
                             input logic [31:0] inst, input logic [THREAD_NUM-1:0] mask,
                             input int lat, input logic res_en,
                             input logic [SPLIT_W-1:0] res_num, input logic [31:0] res_pc);
    sel_valid = 1'b1; sel_pc = pc; sel_num = num; upd_thread_mask = mask;
    tick();
    sel_valid = 1'b0;
    icache_req_ready = 1'b1;
    if (lat > 0) begin
      tick();
      icache_req_ready = 1'b0;
      for (int i = 1; i < lat; i++) tick();
    end
    icache_resp_valid = 1'b1; icache_resp_inst = inst;
    resolve_valid = res_en; resolve_num = res_num; resolve_pc = res_pc;
    tick();
    icache_req_ready = 1'b0; icache_resp_valid = 1'b0; resolve_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; sel_valid = 1'b0; sel_pc = '0; sel_num = '0;
    upd_thread_mask = '0; icache_req_ready = 1'b0; icache_resp_valid = 1'b0;
    icache_resp_inst = '0; dec_ready = 1'b0; resolve_valid = 1'b0; resolve_num = '0; resolve_pc = '0;
    tick(); tick();
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_upd_valid got=%b exp=0", upd_valid); end
    checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b exp=0", icache_req_valid); end
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid got=%b exp=0", dec_valid); end
    checks++; if (icache_req_addr !== 32'h0 || upd_pc !== 32'h0 || dec_inst !== 32'h0 || dec_pc !== 32'h0)
      begin errors++; $display("FAIL reset_zero addr=%h upd_pc=%h inst=%h dec_pc=%h exp=0", icache_req_addr, upd_pc, dec_inst, dec_pc); end
    checks++; if (dec_warp_num !== WARP_W'(WARP_ID)) begin errors++; $display("FAIL reset_warp got=%0d exp=%0d", dec_warp_num, WARP_ID); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_fetch();
    sel_valid = 1'b1; sel_pc = 32'h100; sel_num = SPLIT_W'(0); upd_thread_mask = 8'hA5;
    tick();
    sel_valid = 1'b0;
    checks++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h100)
      begin errors++; $display("FAIL basic_req got=%b/%h exp=1/00000100", icache_req_valid, icache_req_addr); end
    icache_req_ready = 1'b1;
    tick();
    icache_req_ready = 1'b0;
    checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL basic_req_drop got=%b exp=0", icache_req_valid); end
    tick();
    checks++; if (dec_valid !== 1'b0 || upd_valid !== 1'b0) begin errors++; $display("FAIL basic_wait got dec=%b upd=%b exp=0/0", dec_valid, upd_valid); end
    icache_resp_valid = 1'b1; icache_resp_inst = 32'h0000_0033;
    tick();
    icache_resp_valid = 1'b0;
    checks++; if (dec_valid !== 1'b1 || dec_inst !== 32'h33 || dec_pc !== 32'h100 || dec_thread_mask !== 8'hA5 || dec_split_num !== SPLIT_W'(0))
      begin errors++; $display("FAIL basic_dec got v=%b inst=%h pc=%h mask=%h num=%0d exp=1/33/100/a5/0", dec_valid, dec_inst, dec_pc, dec_thread_mask, dec_split_num); end
    checks++; if (upd_valid !== 1'b1 || upd_num !== SPLIT_W'(0) || upd_pc !== 32'h104 || upd_stall !== 1'b0)
      begin errors++; $display("FAIL basic_upd got v=%b num=%0d pc=%h st=%b exp=1/0/104/0", upd_valid, upd_num, upd_pc, upd_stall); end
    tick();
    checks++; if (upd_valid !== 1'b0 || dec_valid !== 1'b1) begin errors++; $display("FAIL basic_pulse got upd=%b dec=%b exp=0/1", upd_valid, dec_valid); end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    checks++; if (dec_valid !== 1'b0 || icache_req_valid !== 1'b0) begin errors++; $display("FAIL basic_idle got dec=%b req=%b exp=0/0", dec_valid, icache_req_valid); end
  endtask

  task automatic test_branch_resolve();
    drive_fetch(32'h200, SPLIT_W'(0), 32'h0000_0063, 8'hFF, 1, 1'b0, '0, '0);
    checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h200 || upd_stall !== 1'b1)
      begin errors++; $display("FAIL branch_upd got v=%b pc=%h st=%b exp=1/200/1", upd_valid, upd_pc, upd_stall); end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    resolve_valid = 1'b1; resolve_num = SPLIT_W'(0); resolve_pc = 32'h300;
    tick();
    resolve_valid = 1'b0;
    checks++; if (upd_valid !== 1'b1 || upd_num !== SPLIT_W'(0) || upd_pc !== 32'h300 || upd_stall !== 1'b0)
      begin errors++; $display("FAIL resolve_upd got v=%b num=%0d pc=%h st=%b exp=1/0/300/0", upd_valid, upd_num, upd_pc, upd_stall); end
    tick();
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL resolve_pulse got=%b exp=0", upd_valid); end
  endtask

  task automatic test_collision();
    drive_fetch(32'h400, SPLIT_W'(1), 32'h0000_0013, 8'h0F, 0, 1'b1, SPLIT_W'(2), 32'h500);
    checks++; if (upd_valid !== 1'b1 || upd_num !== SPLIT_W'(2) || upd_pc !== 32'h500 || upd_stall !== 1'b0)
      begin errors++; $display("FAIL coll_first got v=%b num=%0d pc=%h st=%b exp=1/2/500/0", upd_valid, upd_num, upd_pc, upd_stall); end
    tick();
    checks++; if (upd_valid !== 1'b1 || upd_num !== SPLIT_W'(1) || upd_pc !== 32'h404 || upd_stall !== 1'b0)
      begin errors++; $display("FAIL coll_held got v=%b num=%0d pc=%h st=%b exp=1/1/404/0", upd_valid, upd_num, upd_pc, upd_stall); end
    tick();
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL coll_drain got=%b exp=0", upd_valid); end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
  endtask

  task automatic test_jal();
    drive_fetch(32'h240, SPLIT_W'(3), 32'h0000_006F, 8'h11, 1, 1'b0, '0, '0);
    checks++; if (upd_valid !== 1'b1 || upd_num !== SPLIT_W'(3) || upd_pc !== 32'h240 || upd_stall !== 1'b1)
      begin errors++; $display("FAIL jal_upd got v=%b num=%0d pc=%h st=%b exp=1/3/240/1", upd_valid, upd_num, upd_pc, upd_stall); end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
  endtask

  task automatic test_dec_backpressure();
    drive_fetch(32'h600, SPLIT_W'(3), 32'h0000_0033, 8'h3C, 0, 1'b0, '0, '0);
    checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h604) begin errors++; $display("FAIL bp_upd got v=%b pc=%h exp=1/604", upd_valid, upd_pc); end
    sel_valid = 1'b1; sel_pc = 32'h999; sel_num = SPLIT_W'(2);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'h600 || dec_inst !== 32'h33 || dec_split_num !== SPLIT_W'(3)
          || upd_valid !== 1'b0 || icache_req_valid !== 1'b0 || icache_req_addr !== 32'h600)
        begin errors++; $display("FAIL bp_hold[%0d] got dec=%b pc=%h upd=%b req=%b addr=%h exp=1/600/0/0/600", i, dec_valid, dec_pc, upd_valid, icache_req_valid, icache_req_addr); end
    end
    sel_valid = 1'b0; dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b exp=0", dec_valid); end
  endtask

  task automatic test_rdy_freeze();
    sel_valid = 1'b1; sel_pc = 32'h700; sel_num = SPLIT_W'(1); upd_thread_mask = 8'h0F;
    tick();
    sel_valid = 1'b0; icache_req_ready = 1'b1;
    tick();
    icache_req_ready = 1'b0;
    rdy = 1'b0; icache_resp_valid = 1'b1; icache_resp_inst = 32'h0000_0033;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (dec_valid !== 1'b0 || upd_valid !== 1'b0)
        begin errors++; $display("FAIL frz_hold[%0d] got dec=%b upd=%b exp=0/0", i, dec_valid, upd_valid); end
    end
    rdy = 1'b1;
    tick();
    icache_resp_valid = 1'b0;
    checks++; if (dec_valid !== 1'b1 || dec_inst !== 32'h33 || upd_valid !== 1'b1 || upd_pc !== 32'h704)
      begin errors++; $display("FAIL frz_take got dec=%b inst=%h upd=%b pc=%h exp=1/33/1/704", dec_valid, dec_inst, upd_valid, upd_pc); end
    tick();
    checks++; if (upd_valid !== 1'b0 || dec_valid !== 1'b1) begin errors++; $display("FAIL frz_once got upd=%b dec=%b exp=0/1", upd_valid, dec_valid); end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    sel_valid = 1'b1; sel_pc = 32'h800; sel_num = SPLIT_W'(2);
    tick();
    sel_valid = 1'b0;
    checks++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h800)
      begin errors++; $display("FAIL rstmid_req got=%b/%h exp=1/00000800", icache_req_valid, icache_req_addr); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (icache_req_valid !== 1'b0 || icache_req_addr !== 32'h0 || dec_valid !== 1'b0 || upd_valid !== 1'b0)
      begin errors++; $display("FAIL rstmid_async got req=%b addr=%h dec=%b upd=%b exp=0/0/0/0", icache_req_valid, icache_req_addr, dec_valid, upd_valid); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle got=%b exp=0", icache_req_valid); end
  endtask

  task automatic test_pc_wrap();
    drive_fetch(32'hFFFF_FFFC, SPLIT_W'(0), 32'h0000_0033, 8'h80, 1, 1'b0, '0, '0);
    checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h0 || upd_stall !== 1'b0 || dec_pc !== 32'hFFFF_FFFC)
      begin errors++; $display("FAIL wrap_upd got v=%b pc=%h st=%b dec_pc=%h exp=1/0/0/fffffffc", upd_valid, upd_pc, upd_stall, dec_pc); end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_branch_resolve();
    test_collision();
    test_jal();
    test_dec_backpressure();
    test_rdy_freeze();
    test_reset_mid();
    test_pc_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
